// File: rtl/apb_fifo_periph.sv
// rtl/apb_fifo_periph.sv - APB slave wrapping a byte FIFO with push, pop and status registers
//
// Ports:
//   PCLK     clock, all state updates on the rising edge
//   PRESET   asynchronous active-low reset
//   PSEL     slave select from the APB decoder
//   PENABLE  APB access phase
//   PWRITE   1 = write, 0 = read
//   PADDR    byte address, only [3:2] decoded (0 FSR, 1 FWD, 2 FRD, 3 reserved)
//   PWDATA   write data
//   PRDATA   registered read data, valid while PREADY is high
//   PREADY   registered transfer-complete, high for exactly one cycle per access
module apb_fifo_periph #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             overflow;

    // Side effect decoded in WAIT, committed in DONE.
    logic             op_push;
    logic             op_pop;
    logic             op_clr;
    logic [WIDTH-1:0] wdata;

    logic             empty;
    logic             full;
    logic [31:0]      fsr;
    logic [31:0]      head;
    logic             unused_bits;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign head  = 32'(mem[rd_ptr]);

    // Only the low 8 bits of count fit the status field; at DEPTH=256 a
    // full FIFO shows count 0 with the full flag set.
    always_comb begin
        fsr       = '0;
        fsr[0]    = empty;
        fsr[1]    = full;
        fsr[2]    = overflow;
        fsr[15:8] = 8'(count);
    end

    assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA};

    // The slave leaves IDLE on the setup phase so that the first access
    // cycle is spent in WAIT and PREADY rises on the second access cycle,
    // giving a single wait state.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state    <= IDLE;
            PREADY   <= 1'b0;
            PRDATA   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            op_push  <= 1'b0;
            op_pop   <= 1'b0;
            op_clr   <= 1'b0;
            wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    PREADY <= 1'b0;
                    if (PSEL) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    op_push <= 1'b0;
                    op_pop  <= 1'b0;
                    op_clr  <= 1'b0;
                    if (!PSEL) begin
                        // Master abandoned the transfer: nothing commits.
                        PREADY <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        PREADY <= 1'b1;
                        state  <= DONE;
                        case (PADDR[3:2])
                            2'd0: begin
                                if (PWRITE) op_clr <= PWDATA[2];
                                else        PRDATA <= fsr;
                            end
                            2'd1: begin
                                if (PWRITE) begin
                                    op_push <= 1'b1;
                                    wdata   <= PWDATA[WIDTH-1:0];
                                end else begin
                                    PRDATA <= '0;
                                end
                            end
                            2'd2: begin
                                if (!PWRITE) begin
                                    PRDATA <= empty ? 32'd0 : head;
                                    op_pop <= !empty;
                                end
                            end
                            default: begin
                                if (!PWRITE) PRDATA <= '0;
                            end
                        endcase
                    end
                end
                DONE: begin
                    PREADY <= 1'b0;
                    state  <= IDLE;
                    if (op_push) begin
                        if (full) begin
                            overflow <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + AW'(1);
                            count  <= count + (AW + 1)'(1);
                        end
                    end
                    if (op_pop) begin
                        rd_ptr <= rd_ptr + AW'(1);
                        count  <= count - (AW + 1)'(1);
                    end
                    if (op_clr) begin
                        overflow <= 1'b0;
                    end
                    op_push <= 1'b0;
                    op_pop  <= 1'b0;
                    op_clr  <= 1'b0;
                end
                default: begin
                    PREADY <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Storage is not reset; the write enable comes from reset-cleared state.
    always_ff @(posedge PCLK) begin
        if (state == DONE && op_push && !full) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: tb/tb_apb_fifo_periph.sv
// tb/tb_apb_fifo_periph.sv - self-checking bench for apb_fifo_periph against a queue model
module tb_apb_fifo_periph;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents as a queue, sticky overflow flag.
    localparam int MDEPTH = 8;
    logic [7:0] q[$];
    bit         ovf;

    apb_fifo_periph #(.DEPTH(8), .WIDTH(8)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PRDATA (PRDATA),
        .PREADY (PREADY)
    );

    always #5 PCLK = ~PCLK;

    function automatic logic [31:0] model_fsr();
        logic [31:0] v;
        v = 32'(q.size()) << 8;
        if (ovf)              v = v | 32'h4;
        if (q.size() == MDEPTH) v = v | 32'h2;
        if (q.size() == 0)    v = v | 32'h1;
        return v;
    endfunction

    // Apply one access to the model; exp is the value a read must return.
    task automatic model_access(input bit w, input logic [1:0] r, input logic [31:0] d,
                                output logic [31:0] exp);
        exp = 32'd0;
        case (r)
            2'd0: begin
                if (w) begin
                    if (d[2]) ovf = 1'b0;
                end else begin
                    exp = model_fsr();
                end
            end
            2'd1: begin
                if (w) begin
                    if (q.size() == MDEPTH) ovf = 1'b1;
                    else q.push_back(d[7:0]);
                end
            end
            2'd2: begin
                if (!w && q.size() > 0) exp = 32'(q.pop_front());
            end
            default: ;
        endcase
    endtask

    // One APB transfer; returns at the falling edge of the PREADY cycle,
    // leaving the bus driven so a following transfer can go back-to-back.
    task automatic xfer(input bit w, input logic [1:0] r, input logic [31:0] d,
                        output logic [31:0] rd, output int cyc);
        @(posedge PCLK); #1;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = w;
        PADDR   = ($urandom() & 32'hFFFF_FFF3) | (32'(r) << 2);
        PWDATA  = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        cyc = 0;
        rd  = 32'hDEAD_BEEF;
        for (int i = 1; i <= 8; i++) begin
            @(negedge PCLK);
            if (PREADY) begin
                cyc = i;
                rd  = PRDATA;
                break;
            end
        end
    endtask

    task automatic bus_idle();
        @(posedge PCLK); #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int          cyc;
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        q.delete(); ovf = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        total++; if (PREADY !== 1'b0) begin bad++; $display("FAIL reset_pready got=%b want=0", PREADY); end
        total++; if (PRDATA !== 32'd0) begin bad++; $display("FAIL reset_prdata got=%h want=0", PRDATA); end
        PRESET = 1'b1;
        xfer(1'b0, 2'd0, 32'd0, rd, cyc); bus_idle();
        total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL reset_fsr got=%h want=00000001", rd); end
        total++; if (cyc != 2) begin bad++; $display("FAIL reset_ready_cycle got=%0d want=2", cyc); end
    endtask

    task automatic test_basic();
        logic [31:0] rd, exp;
        int          cyc;
        logic [31:0] vals [4] = '{32'h0000_00A5, 32'h0000_003C, 32'h0000_00A5, 32'h0000_003C};
        for (int i = 0; i < 2; i++) begin
            xfer(1'b1, 2'd1, vals[i], rd, cyc); bus_idle();
            model_access(1'b1, 2'd1, vals[i], exp);
            total++; if (cyc != 2) begin bad++; $display("FAIL push_ready_cycle got=%0d want=2", cyc); end
        end
        xfer(1'b0, 2'd0, 32'd0, rd, cyc); bus_idle();
        model_access(1'b0, 2'd0, 32'd0, exp);
        total++; if (rd !== 32'h0000_0200 || exp !== 32'h0000_0200) begin bad++; $display("FAIL basic_fsr got=%h want=00000200", rd); end
        for (int i = 2; i < 4; i++) begin
            xfer(1'b0, 2'd2, 32'd0, rd, cyc); bus_idle();
            model_access(1'b0, 2'd2, 32'd0, exp);
            total++; if (rd !== vals[i]) begin bad++; $display("FAIL basic_pop%0d got=%h want=%h", i - 2, rd, vals[i]); end
        end
        // PRDATA holds the last read value after the transfer ends.
        @(negedge PCLK);
        total++; if (PRDATA !== 32'h0000_003C) begin bad++; $display("FAIL prdata_hold got=%h want=0000003c", PRDATA); end
        xfer(1'b0, 2'd0, 32'd0, rd, cyc); bus_idle();
        model_access(1'b0, 2'd0, 32'd0, exp);
        total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL basic_fsr_empty got=%h want=00000001", rd); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd, exp;
        int          cyc;
        for (int i = 1; i <= 9; i++) begin
            xfer(1'b1, 2'd1, 32'(i), rd, cyc); bus_idle();
            model_access(1'b1, 2'd1, 32'(i), exp);
        end
        xfer(1'b0, 2'd0, 32'd0, rd, cyc); bus_idle();
        total++; if (rd !== 32'h0000_0806) begin bad++; $display("FAIL ovf_fsr_full got=%h want=00000806", rd); end
        for (int i = 1; i <= 8; i++) begin
            xfer(1'b0, 2'd2, 32'd0, rd, cyc); bus_idle();
            model_access(1'b0, 2'd2, 32'd0, exp);
            total++; if (rd !== 32'(i)) begin bad++; $display("FAIL ovf_pop%0d got=%h want=%h", i, rd, 32'(i)); end
        end
        // Pop while empty: returns 0, count stays 0, overflow still set.
        xfer(1'b0, 2'd2, 32'd0, rd, cyc); bus_idle();
        model_access(1'b0, 2'd2, 32'd0, exp);
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL empty_pop got=%h want=00000000", rd); end
        xfer(1'b0, 2'd0, 32'd0, rd, cyc); bus_idle();
        model_access(1'b0, 2'd0, 32'd0, exp);
        total++; if (rd !== exp || rd !== 32'h0000_0005) begin bad++; $display("FAIL empty_pop_fsr got=%h want=00000005", rd); end
        xfer(1'b1, 2'd0, 32'h4, rd, cyc); bus_idle();
        model_access(1'b1, 2'd0, 32'h4, exp);
        xfer(1'b0, 2'd0, 32'd0, rd, cyc); bus_idle();
        total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL ovf_clear got=%h want=00000001", rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd, exp, d;
        int          cyc;
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 6; i++) begin
                d = $urandom();
                xfer(1'b1, 2'd1, d, rd, cyc); bus_idle();
                model_access(1'b1, 2'd1, d, exp);
            end
            for (int i = 0; i < 6; i++) begin
                xfer(1'b0, 2'd2, 32'd0, rd, cyc); bus_idle();
                model_access(1'b0, 2'd2, 32'd0, exp);
                total++; if (rd !== exp) begin bad++; $display("FAIL wrap_r%0d_i%0d got=%h want=%h", round, i, rd, exp); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, exp, d;
        logic [1:0]  r;
        bit          w;
        int          cyc;
        for (int i = 0; i < 150; i++) begin
            r = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) r = 2'd1;
            d = (r == 2'd0 && $urandom_range(0, 3) != 0) ? ($urandom() & 32'hFFFF_FFFB) : $urandom();
            xfer(w, r, d, rd, cyc);
            if ($urandom_range(0, 1) == 0) bus_idle();
            model_access(w, r, d, exp);
            total++; if (cyc != 2) begin bad++; $display("FAIL b2b_ready_cycle%0d got=%0d want=2", i, cyc); end
            if (!w) begin
                total++; if (rd !== exp) begin bad++; $display("FAIL b2b_read%0d reg=%0d got=%h want=%h", i, r, rd, exp); end
            end
        end
        bus_idle();
    endtask

    task automatic test_psel_drop();
        logic [31:0] rd, exp;
        int          cyc;
        bit          saw_ready;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'h77;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b1;
        saw_ready = 1'b0;
        repeat (3) begin
            @(negedge PCLK);
            if (PREADY) saw_ready = 1'b1;
        end
        total++; if (saw_ready) begin bad++; $display("FAIL psel_drop_ready got=1 want=0"); end
        PENABLE = 1'b0;
        xfer(1'b0, 2'd0, 32'd0, rd, cyc); bus_idle();
        model_access(1'b0, 2'd0, 32'd0, exp);
        total++; if (rd !== exp) begin bad++; $display("FAIL psel_drop_fsr got=%h want=%h", rd, exp); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, exp;
        int          cyc;
        for (int i = 0; i < 3; i++) begin
            xfer(1'b1, 2'd1, 32'h50 + 32'(i), rd, cyc); bus_idle();
            model_access(1'b1, 2'd1, 32'h50 + 32'(i), exp);
        end
        // Reset during the WAIT cycle of an FWD write.
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'h99;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2 PRESET = 1'b0;
        #1;
        total++; if (PREADY !== 1'b0) begin bad++; $display("FAIL rst_wait_pready got=%b want=0", PREADY); end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        q.delete(); ovf = 1'b0;
        xfer(1'b0, 2'd0, 32'd0, rd, cyc); bus_idle();
        total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL rst_wait_fsr got=%h want=00000001", rd); end
        // Reset during the PREADY cycle of a push: PREADY drops at once, push lost.
        xfer(1'b1, 2'd1, 32'h66, rd, cyc);
        PRESET = 1'b0;
        #1;
        total++; if (PREADY !== 1'b0) begin bad++; $display("FAIL rst_done_pready got=%b want=0", PREADY); end
        #1 PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        xfer(1'b0, 2'd0, 32'd0, rd, cyc); bus_idle();
        total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL rst_done_fsr got=%h want=00000001", rd); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_wrap();
        test_back_to_back();
        test_psel_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
